// File: rtl/wishbone_rr_arbiter.sv
// Two-master / one-slave Wishbone arbiter with round-robin priority and registered outputs.
// Optional BUSY watchdog is built when the macro WB_ARB_TIMEOUT_EN is defined.
module wishbone_rr_arbiter #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        wb_m0_cycle,
    input  logic        wb_m0_strobe,
    input  logic [31:0] wb_m0_address,
    input  logic [3:0]  wb_m0_select,
    input  logic        wb_m0_write_enable,
    input  logic [31:0] wb_m0_data_in,
    output logic        wb_m0_ack,
    output logic [31:0] wb_m0_data_out,

    input  logic        wb_m1_cycle,
    input  logic        wb_m1_strobe,
    input  logic [31:0] wb_m1_address,
    input  logic [3:0]  wb_m1_select,
    input  logic        wb_m1_write_enable,
    input  logic [31:0] wb_m1_data_in,
    output logic        wb_m1_ack,
    output logic [31:0] wb_m1_data_out,

    output logic        wb_s_cycle,
    output logic        wb_s_strobe,
    output logic [31:0] wb_s_address,
    output logic [3:0]  wb_s_select,
    output logic        wb_s_write_enable,
    output logic [31:0] wb_s_data_in,
    input  logic        wb_s_ack,
    input  logic [31:0] wb_s_data_out,

    output logic [1:0]  grant,
    output logic        timeout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    logic [1:0]  state_r;
    logic        last_grant_r;      // 1'b1 = m1 was served last
    logic [1:0]  grant_r;
    logic        timeout_r;

    logic        s_cycle_r;
    logic [31:0] s_address_r;
    logic [3:0]  s_select_r;
    logic        s_write_enable_r;
    logic [31:0] s_data_in_r;

    logic        m0_ack_r;
    logic [31:0] m0_data_out_r;
    logic        m1_ack_r;
    logic [31:0] m1_data_out_r;

    logic        req0_s;
    logic        req1_s;
    logic        any_req_s;
    logic        pick_m1_s;
    logic [31:0] pick_address_s;
    logic [3:0]  pick_select_s;
    logic        pick_write_enable_s;
    logic [31:0] pick_data_in_s;

    logic        timeout_hit_s;
    logic        busy_done_s;
    logic [31:0] done_data_s;

    // Request decode and round-robin winner selection.
    always_comb begin
        req0_s    = wb_m0_cycle && wb_m0_strobe;
        req1_s    = wb_m1_cycle && wb_m1_strobe;
        any_req_s = req0_s || req1_s;
        if (req0_s && req1_s) begin
            pick_m1_s = ~last_grant_r;
        end else begin
            pick_m1_s = req1_s;
        end
    end

    // Route the winning master's request fields toward the slave latches.
    always_comb begin
        if (pick_m1_s) begin
            pick_address_s      = wb_m1_address;
            pick_select_s       = wb_m1_select;
            pick_write_enable_s = wb_m1_write_enable;
            pick_data_in_s      = wb_m1_data_in;
        end else begin
            pick_address_s      = wb_m0_address;
            pick_select_s       = wb_m0_select;
            pick_write_enable_s = wb_m0_write_enable;
            pick_data_in_s      = wb_m0_data_in;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt_r;

    // Watchdog counts BUSY cycles; it is held at zero everywhere else.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_BUSY) begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1);
        end else begin
            wd_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Expiry on the last allowed BUSY cycle; a simultaneous slave ack wins.
    always_comb begin
        if ((state_r == ST_BUSY) && !wb_s_ack && (wd_cnt_r == CNT_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Completion of the slave phase and the data handed back to the master.
    always_comb begin
        busy_done_s = (state_r == ST_BUSY) && (wb_s_ack || timeout_hit_s);
        if (timeout_hit_s) begin
            done_data_s = TIMEOUT_DATA;
        end else begin
            done_data_s = wb_s_data_out;
        end
    end

    // Arbitration FSM and grant bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            grant_r      <= 2'b00;
            timeout_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timeout_r <= 1'b0;
                    if (any_req_s) begin
                        grant_r      <= pick_m1_s ? 2'b10 : 2'b01;
                        last_grant_r <= pick_m1_s;
                        state_r      <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (busy_done_s) begin
                        timeout_r <= timeout_hit_s;
                        state_r   <= ST_ACK;
                    end else begin
                        timeout_r <= 1'b0;
                        state_r   <= ST_BUSY;
                    end
                end
                ST_ACK: begin
                    grant_r   <= 2'b00;
                    timeout_r <= 1'b0;
                    state_r   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    timeout_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    grant_r   <= 2'b00;
                    timeout_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Slave-side request latches; fields stay stable for the whole BUSY phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_cycle_r        <= 1'b0;
            s_address_r      <= 32'h0000_0000;
            s_select_r       <= 4'b0000;
            s_write_enable_r <= 1'b0;
            s_data_in_r      <= 32'h0000_0000;
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            s_cycle_r        <= 1'b1;
            s_address_r      <= pick_address_s - BASE_ADDR;
            s_select_r       <= pick_select_s;
            s_write_enable_r <= pick_write_enable_s;
            s_data_in_r      <= pick_data_in_s;
        end else if (busy_done_s) begin
            s_cycle_r <= 1'b0;
        end else begin
            s_cycle_r <= s_cycle_r;
        end
    end

    // Master acks pulse for the single ACK cycle; read data persists afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_ack_r      <= 1'b0;
            m0_data_out_r <= 32'h0000_0000;
            m1_ack_r      <= 1'b0;
            m1_data_out_r <= 32'h0000_0000;
        end else if (busy_done_s) begin
            if (grant_r[1]) begin
                m1_ack_r      <= 1'b1;
                m1_data_out_r <= done_data_s;
            end else begin
                m0_ack_r      <= 1'b1;
                m0_data_out_r <= done_data_s;
            end
        end else begin
            m0_ack_r <= 1'b0;
            m1_ack_r <= 1'b0;
        end
    end

    assign wb_s_cycle        = s_cycle_r;
    assign wb_s_strobe       = s_cycle_r;
    assign wb_s_address      = s_address_r;
    assign wb_s_select       = s_select_r;
    assign wb_s_write_enable = s_write_enable_r;
    assign wb_s_data_in      = s_data_in_r;

    assign wb_m0_ack      = m0_ack_r;
    assign wb_m0_data_out = m0_data_out_r;
    assign wb_m1_ack      = m1_ack_r;
    assign wb_m1_data_out = m1_data_out_r;

    assign grant   = grant_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Scoreboard bench for wishbone_rr_arbiter: directed master traffic, a latency-programmable slave,
// and a monitor checking slave requests and master acks against queued expectations.
module tb_wishbone_rr_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
        logic [1:0]  grant;
    } sreq_t;

    typedef struct packed {
        logic        mid;
        logic [31:0] data;
        logic        to;
        logic [7:0]  lat;
    } ack_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_m0_cycle, wb_m0_strobe, wb_m0_write_enable, wb_m0_ack;
    logic [31:0] wb_m0_address, wb_m0_data_in, wb_m0_data_out;
    logic [3:0]  wb_m0_select;
    logic        wb_m1_cycle, wb_m1_strobe, wb_m1_write_enable, wb_m1_ack;
    logic [31:0] wb_m1_address, wb_m1_data_in, wb_m1_data_out;
    logic [3:0]  wb_m1_select;
    logic        wb_s_cycle, wb_s_strobe, wb_s_write_enable, wb_s_ack;
    logic [31:0] wb_s_address, wb_s_data_in, wb_s_data_out;
    logic [3:0]  wb_s_select;
    logic [1:0]  grant;
    logic        timeout;

    sreq_t       sq[$];
    ack_t        aq[$];
    logic [31:0] resp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          slave_lat = 1;

    wishbone_rr_arbiter dut (
        .clk(clk), .reset(reset),
        .wb_m0_cycle(wb_m0_cycle), .wb_m0_strobe(wb_m0_strobe), .wb_m0_address(wb_m0_address),
        .wb_m0_select(wb_m0_select), .wb_m0_write_enable(wb_m0_write_enable),
        .wb_m0_data_in(wb_m0_data_in), .wb_m0_ack(wb_m0_ack), .wb_m0_data_out(wb_m0_data_out),
        .wb_m1_cycle(wb_m1_cycle), .wb_m1_strobe(wb_m1_strobe), .wb_m1_address(wb_m1_address),
        .wb_m1_select(wb_m1_select), .wb_m1_write_enable(wb_m1_write_enable),
        .wb_m1_data_in(wb_m1_data_in), .wb_m1_ack(wb_m1_ack), .wb_m1_data_out(wb_m1_data_out),
        .wb_s_cycle(wb_s_cycle), .wb_s_strobe(wb_s_strobe), .wb_s_address(wb_s_address),
        .wb_s_select(wb_s_select), .wb_s_write_enable(wb_s_write_enable),
        .wb_s_data_in(wb_s_data_in), .wb_s_ack(wb_s_ack), .wb_s_data_out(wb_s_data_out),
        .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void flag(string name, string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, what);
    endfunction

    task automatic drive_m(input logic mid, input logic on, input logic [31:0] addr,
                           input logic [3:0] sel, input logic we, input logic [31:0] wdata);
        if (mid) begin
            wb_m1_cycle = on; wb_m1_strobe = on; wb_m1_address = addr;
            wb_m1_select = sel; wb_m1_write_enable = we; wb_m1_data_in = wdata;
        end else begin
            wb_m0_cycle = on; wb_m0_strobe = on; wb_m0_address = addr;
            wb_m0_select = sel; wb_m0_write_enable = we; wb_m0_data_in = wdata;
        end
    endtask

    task automatic master_txn(input logic mid, input logic [31:0] addr, input logic [3:0] sel,
                              input logic we, input logic [31:0] wdata, input logic hold);
        logic got;
        got = 1'b0;
        drive_m(mid, 1'b1, addr, sel, we, wdata);
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            got = mid ? wb_m1_ack : wb_m0_ack;
        end
        if (!got) flag(mid ? "m1_ack_wait" : "m0_ack_wait", "got no ack, expected ack within 200 cycles");
        if (hold) begin
            repeat (2) @(posedge clk);
            #1;
        end
        drive_m(mid, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    // Slave model: acks slave_lat cycles after the strobe is first seen.
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        wb_s_ack = 1'b0;
        wb_s_data_out = 32'h0;
        forever begin
            @(posedge clk); #1;
            wb_s_ack = 1'b0;
            if (wb_s_cycle && wb_s_strobe) begin
                if (lat_cnt == slave_lat) begin
                    wb_s_ack = 1'b1;
                    wb_s_data_out = (resp_q.size() > 0) ? resp_q.pop_front() : 32'h0;
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Monitor: compares each new slave strobe and each master ack against the scoreboard.
    initial begin
        logic  prev_stb, prev_ack;
        int    strobe_cyc;
        sreq_t s;
        ack_t  a;
        prev_stb = 1'b0;
        prev_ack = 1'b0;
        strobe_cyc = 0;
        forever begin
            @(negedge clk);
            if (wb_s_strobe && !prev_stb) begin
                strobe_cyc = cyc;
                if (sq.size() == 0) begin
                    flag("s_strobe", "slave strobe seen, none expected");
                end else begin
                    s = sq.pop_front();
                    chk("s_address", wb_s_address, s.addr);
                    chk("s_select", {28'h0, wb_s_select}, {28'h0, s.sel});
                    chk("s_we", {31'h0, wb_s_write_enable}, {31'h0, s.we});
                    chk("s_data_in", wb_s_data_in, s.wdata);
                    chk("grant_busy", {30'h0, grant}, {30'h0, s.grant});
                end
            end
            if (wb_m0_ack && wb_m1_ack) flag("ack_overlap", "m0 ack and m1 ack both high");
            if (wb_m0_ack || wb_m1_ack) begin
                if (prev_ack) begin
                    flag("ack_width", "master ack high for more than one cycle");
                end else if (aq.size() == 0) begin
                    flag("m_ack", "master ack seen, none expected");
                end else begin
                    a = aq.pop_front();
                    chk("ack_master", {31'h0, wb_m1_ack}, {31'h0, a.mid});
                    chk("m_data_out", a.mid ? wb_m1_data_out : wb_m0_data_out, a.data);
                    chk("timeout_pulse", {31'h0, timeout}, {31'h0, a.to});
                    chk("ack_latency", cyc - strobe_cyc, {24'h0, a.lat});
                end
            end else if (timeout) begin
                flag("timeout_pulse", "timeout high without a master ack");
            end
            prev_stb = wb_s_strobe;
            prev_ack = wb_m0_ack || wb_m1_ack;
        end
    end

    initial begin
        reset = 1'b1;
        drive_m(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        drive_m(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_cycle", {31'h0, wb_s_cycle}, 32'h0);
        chk("rst_s_strobe", {31'h0, wb_s_strobe}, 32'h0);
        chk("rst_s_address", wb_s_address, 32'h0);
        chk("rst_s_data_in", wb_s_data_in, 32'h0);
        chk("rst_grant", {30'h0, grant}, 32'h0);
        chk("rst_timeout", {31'h0, timeout}, 32'h0);
        chk("rst_m0_ack", {31'h0, wb_m0_ack}, 32'h0);
        chk("rst_m1_data", wb_m1_data_out, 32'h0);
        reset = 1'b0;

        // Simultaneous requests out of reset: m0 first, then m1.
        slave_lat = 1;
        sq.push_back('{32'h0000_0020, 4'hF, 1'b0, 32'h0, 2'b01});
        sq.push_back('{32'h0000_0030, 4'hF, 1'b0, 32'h0, 2'b10});
        resp_q.push_back(32'h1111_1111);
        resp_q.push_back(32'h2222_2222);
        aq.push_back('{1'b0, 32'h1111_1111, 1'b0, 8'd2});
        aq.push_back('{1'b1, 32'h2222_2222, 1'b0, 8'd2});
        fork
            master_txn(1'b0, 32'h8000_0020, 4'hF, 1'b0, 32'h0, 1'b0);
            master_txn(1'b1, 32'h8000_0030, 4'hF, 1'b0, 32'h0, 1'b0);
        join

        // m0 read with slave latency 2.
        slave_lat = 2;
        sq.push_back('{32'h0000_0010, 4'hF, 1'b0, 32'h0, 2'b01});
        resp_q.push_back(32'hCAFE_F00D);
        aq.push_back('{1'b0, 32'hCAFE_F00D, 1'b0, 8'd3});
        master_txn(1'b0, 32'h8000_0010, 4'hF, 1'b0, 32'h0, 1'b0);

        // m1 partial write.
        slave_lat = 1;
        sq.push_back('{32'h0000_0004, 4'b0011, 1'b1, 32'h1234_5678, 2'b10});
        resp_q.push_back(32'h0BAD_C0DE);
        aq.push_back('{1'b1, 32'h0BAD_C0DE, 1'b0, 8'd2});
        master_txn(1'b1, 32'h8000_0004, 4'b0011, 1'b1, 32'h1234_5678, 1'b0);

        // m0 keeps strobe up through SETTLE: exactly one slave strobe allowed.
        sq.push_back('{32'h0000_0040, 4'hF, 1'b0, 32'h0, 2'b01});
        resp_q.push_back(32'h4444_4444);
        aq.push_back('{1'b0, 32'h4444_4444, 1'b0, 8'd2});
        master_txn(1'b0, 32'h8000_0040, 4'hF, 1'b0, 32'h0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("stale_strobe", {31'h0, wb_s_strobe}, 32'h0);
        chk("stale_grant", {30'h0, grant}, 32'h0);

        // Reset in BUSY abandons the slave cycle with no ack.
        slave_lat = 255;
        sq.push_back('{32'h0000_0050, 4'hF, 1'b0, 32'h0, 2'b10});
        drive_m(1'b1, 1'b1, 32'h8000_0050, 4'hF, 1'b0, 32'h0);
        for (int i = 0; i < 10 && !wb_s_strobe; i++) begin
            @(posedge clk); #1;
        end
        chk("busy_reached", {31'h0, wb_s_strobe}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_s_cycle", {31'h0, wb_s_cycle}, 32'h0);
        chk("mid_rst_grant", {30'h0, grant}, 32'h0);
        chk("mid_rst_acks", {30'h0, wb_m1_ack, wb_m0_ack}, 32'h0);
        chk("mid_rst_m0_data", wb_m0_data_out, 32'h0);
        chk("mid_rst_m1_data", wb_m1_data_out, 32'h0);
        drive_m(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        reset = 1'b0;
        slave_lat = 1;
        sq.push_back('{32'h0000_0060, 4'hF, 1'b0, 32'h0, 2'b10});
        resp_q.push_back(32'h6666_6666);
        aq.push_back('{1'b1, 32'h6666_6666, 1'b0, 8'd2});
        master_txn(1'b1, 32'h8000_0060, 4'hF, 1'b0, 32'h0, 1'b0);

`ifdef WB_ARB_TIMEOUT_EN
        // Silent slave: watchdog answers at BUSY cycle 16.
        slave_lat = 255;
        sq.push_back('{32'h0000_0070, 4'hF, 1'b0, 32'h0, 2'b01});
        aq.push_back('{1'b0, 32'hDEAD_BEEF, 1'b1, 8'd16});
        master_txn(1'b0, 32'h8000_0070, 4'hF, 1'b0, 32'h0, 1'b0);
        // Slave ack landing in the expiry cycle wins.
        slave_lat = 15;
        sq.push_back('{32'h0000_0080, 4'hF, 1'b0, 32'h0, 2'b10});
        resp_q.push_back(32'h8888_8888);
        aq.push_back('{1'b1, 32'h8888_8888, 1'b0, 8'd16});
        master_txn(1'b1, 32'h8000_0080, 4'hF, 1'b0, 32'h0, 1'b0);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("slave_q_drained", sq.size(), 32'h0);
        chk("ack_q_drained", aq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
